// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin on ties, grant held for
// the whole CYC, and a watchdog that turns a hung access into an ERR pulse.
module wb_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    // master 0: instruction fetch
    input  logic            M0_CYC_I,
    input  logic            M0_STB_I,
    input  logic            M0_WE_I,
    input  logic [AW-1:0]   M0_ADR_I,
    input  logic [DW-1:0]   M0_DAT_I,
    input  logic [DW/8-1:0] M0_SEL_I,
    output logic [DW-1:0]   M0_DAT_O,
    output logic            M0_ACK_O,
    output logic            M0_ERR_O,
    // master 1: data
    input  logic            M1_CYC_I,
    input  logic            M1_STB_I,
    input  logic            M1_WE_I,
    input  logic [AW-1:0]   M1_ADR_I,
    input  logic [DW-1:0]   M1_DAT_I,
    input  logic [DW/8-1:0] M1_SEL_I,
    output logic [DW-1:0]   M1_DAT_O,
    output logic            M1_ACK_O,
    output logic            M1_ERR_O,
    // slave
    output logic            S_CYC_O,
    output logic            S_STB_O,
    output logic            S_WE_O,
    output logic [AW-1:0]   S_ADR_O,
    output logic [DW-1:0]   S_DAT_O,
    output logic [DW/8-1:0] S_SEL_O,
    input  logic [DW-1:0]   S_DAT_I,
    input  logic            S_ACK_I,
    input  logic            S_ERR_I
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_GNT0  = 2'd1;
    localparam logic [1:0]  ST_GNT1  = 2'd2;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last_grant;
    logic        w_last_grant_nxt;
    logic [15:0] r_tmo_cnt;
    logic [15:0] w_tmo_cnt_nxt;

    logic        w_req0;
    logic        w_req1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_stb_mux;
    logic        w_busy;
    logic        w_timeout_hit;

    assign w_req0    = M0_CYC_I & M0_STB_I;
    assign w_req1    = M1_CYC_I & M1_STB_I;
    assign w_gnt0    = (r_state == ST_GNT0);
    assign w_gnt1    = (r_state == ST_GNT1);
    assign w_stb_mux = (w_gnt0 & M0_STB_I) | (w_gnt1 & M1_STB_I);

    // a strobed access still waiting for its slave termination
    assign w_busy        = w_stb_mux & ~S_ACK_I & ~S_ERR_I;
    assign w_timeout_hit = w_busy & (r_tmo_cnt == TMO_LAST);

    // read data is broadcast; only ACK qualifies it
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

    // state, round-robin pointer and watchdog registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_tmo_cnt    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
        end
    end

    // next-state: arbitrate only from IDLE, hold grant while CYC stays high
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    if (r_last_grant) begin
                        w_state_nxt      = ST_GNT0;
                        w_last_grant_nxt = 1'b0;
                    end else begin
                        w_state_nxt      = ST_GNT1;
                        w_last_grant_nxt = 1'b1;
                    end
                end else if (w_req0) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: if (!M0_CYC_I) w_state_nxt = ST_IDLE;
            ST_GNT1: if (!M1_CYC_I) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // watchdog: count unterminated strobed cycles, clear on hit or any break
    always_comb begin
        w_tmo_cnt_nxt = 16'd0;
        if (w_busy && !w_timeout_hit) begin
            w_tmo_cnt_nxt = (r_tmo_cnt == 16'hFFFF) ? r_tmo_cnt : r_tmo_cnt + 16'd1;
        end
    end

    // bus mux and termination routing, decoded from the registered grant
    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_SEL_O  = '0;
        M0_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ACK_O = 1'b0;
        M1_ERR_O = 1'b0;
        if (w_gnt0) begin
            S_CYC_O  = M0_CYC_I;
            S_STB_O  = M0_STB_I;
            S_WE_O   = M0_WE_I;
            S_ADR_O  = M0_ADR_I;
            S_DAT_O  = M0_DAT_I;
            S_SEL_O  = M0_SEL_I;
            M0_ACK_O = S_ACK_I;
            M0_ERR_O = S_ERR_I | w_timeout_hit;
        end else if (w_gnt1) begin
            S_CYC_O  = M1_CYC_I;
            S_STB_O  = M1_STB_I;
            S_WE_O   = M1_WE_I;
            S_ADR_O  = M1_ADR_I;
            S_DAT_O  = M1_DAT_I;
            S_SEL_O  = M1_SEL_I;
            M1_ACK_O = S_ACK_I;
            M1_ERR_O = S_ERR_I | w_timeout_hit;
        end
    end

    // slave protocol check: ACK and ERR must never coincide
    always @(posedge CLK_I) begin
        assert (RST_I || !(S_ACK_I && S_ERR_I))
            else $warning("wb_bus_arbiter: slave asserted ACK and ERR together");
    end

endmodule
